// File: rtl/sync_debounce_pkg.sv
// Shared FSM encodings and the width helper for the sync_debounce block.
package sync_debounce_pkg;

   typedef enum logic [1:0] {
      ST_LO  = 2'd0,
      CHK_HI = 2'd1,
      ST_HI  = 2'd2,
      CHK_LO = 2'd3
   } state_t;

   // Bits needed to hold 0..v-1; never less than one bit.
   function automatic int clog2(input int v);
      int w;
      w = 0;
      for (int k = 0; k < 31; k++) begin
         if ((1 << k) < v) w = k + 1;
      end
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sync_debounce_args_sync.sv
// N-flop level synchronizer (module args_sync); the chain is not reset and
// reads as INIT from power-up.
module args_sync #(
   parameter int   N    = 2,
   parameter logic INIT = 1'b0
) (
   input  logic c,
   input  logic d,
   output logic q
);

   logic [N-1:0] sync_q;
   logic [N-1:0] sync_d;

   // Flops hold the level relative to INIT, so the all-zero power-up state reads as INIT.
   always_comb sync_d = {sync_q[N-2:0], d ^ INIT};

   always_ff @(posedge c) begin
      sync_q <= sync_d;
   end

   assign q = sync_q[N-1] ^ INIT;

endmodule

// File: rtl/sync_debounce.sv
// Synchronizer plus debounce FSM with edge pulses and a wrapping edge counter.
// Optional glitch counter output enabled by SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int   N        = 2,
   parameter int   DEBOUNCE = 4,
   parameter logic INIT     = 1'b0,
   parameter int   EVT_W    = 8
) (
   input  logic             c,
   input  logic             r,
   input  logic             i,
   input  logic             clr,
   output logic             o,
   output logic             rise,
   output logic             fall,
   output logic             glitch,
   output logic [EVT_W-1:0] evt_cnt,
   output logic [1:0]       dbg_state
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   ,
   output logic [EVT_W-1:0] glitch_cnt
`endif
);

   localparam int CW = clog2(DEBOUNCE);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   if (DEBOUNCE < 2) begin : g_bad_debounce
      $error("sync_debounce: DEBOUNCE must be at least 2");
   end
   if (N < 2) begin : g_bad_n
      $error("sync_debounce: N must be at least 2");
   end

   logic s;

   args_sync #(.N(N), .INIT(INIT)) u_sync (
      .c (c),
      .d (i),
      .q (s)
   );

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             o_q, o_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             glitch_q, glitch_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   logic             accept;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      o_d      = o_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      glitch_d = 1'b0;
      accept   = 1'b0;
      case (state_q)
         ST_LO: begin
            if (s) begin
               state_d = CHK_HI;
               cnt_d   = CW'(1);
            end
         end
         CHK_HI: begin
            if (!s) begin
               state_d  = ST_LO;
               glitch_d = 1'b1;
               cnt_d    = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_HI;
               o_d     = 1'b1;
               rise_d  = 1'b1;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_HI: begin
            if (!s) begin
               state_d = CHK_LO;
               cnt_d   = CW'(1);
            end
         end
         CHK_LO: begin
            if (s) begin
               state_d  = ST_HI;
               glitch_d = 1'b1;
               cnt_d    = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = ST_LO;
               o_d     = 1'b0;
               fall_d  = 1'b1;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_LO;
            cnt_d   = '0;
         end
      endcase
      // A clear on the same edge as an accepted transition still zeroes the count.
      evt_d = clr ? '0 : evt_q + EVT_W'(accept);
   end

   always_ff @(posedge c or posedge r) begin
      if (r) begin
         state_q  <= INIT ? ST_HI : ST_LO;
         cnt_q    <= '0;
         o_q      <= INIT;
         rise_q   <= 1'b0;
         fall_q   <= 1'b0;
         glitch_q <= 1'b0;
         evt_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         o_q      <= o_d;
         rise_q   <= rise_d;
         fall_q   <= fall_d;
         glitch_q <= glitch_d;
         evt_q    <= evt_d;
      end
   end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [EVT_W-1:0] gcnt_q, gcnt_d;

   always_comb gcnt_d = clr ? '0 : gcnt_q + EVT_W'(glitch_d);

   always_ff @(posedge c or posedge r) begin
      if (r) gcnt_q <= '0;
      else   gcnt_q <= gcnt_d;
   end

   assign glitch_cnt = gcnt_q;
`endif

   assign o         = o_q;
   assign rise      = rise_q;
   assign fall      = fall_q;
   assign glitch    = glitch_q;
   assign evt_cnt   = evt_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sync_debounce.sv
// Bench for sync_debounce: run-length debounce model checked every cycle,
// directed scenarios with literal expectations, then randomized input runs.
module tb_sync_debounce;
   import sync_debounce_pkg::*;

   localparam int N   = 2;
   localparam int DEB = 4;
   localparam int EW  = 4;

   logic          c = 1'b0;
   logic          r, i, clr, i1;
   logic          o, rise, fall, glitch;
   logic          o1, rise1, fall1, glitch1;
   logic [EW-1:0] evt, evt1;
   logic [1:0]    st, st1;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
   logic [EW-1:0] gcnt, gcnt1;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- clock ----------------
   always #5 c = ~c;

   // ---------------- DUTs ----------------
   sync_debounce #(.N(N), .DEBOUNCE(DEB), .INIT(1'b0), .EVT_W(EW)) dut (
      .c (c), .r (r), .i (i), .clr (clr),
      .o (o), .rise (rise), .fall (fall), .glitch (glitch),
      .evt_cnt (evt), .dbg_state (st)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      , .glitch_cnt (gcnt)
`endif
   );

   sync_debounce #(.N(N), .DEBOUNCE(DEB), .INIT(1'b1), .EVT_W(EW)) dut1 (
      .c (c), .r (r), .i (i1), .clr (clr),
      .o (o1), .rise (rise1), .fall (fall1), .glitch (glitch1),
      .evt_cnt (evt1), .dbg_state (st1)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      , .glitch_cnt (gcnt1)
`endif
   );

   // ---------------- reference model ----------------
   // Level plus length of the current run of samples disagreeing with it.
   logic          hist[$];
   int            pend;
   logic          m_o, m_rise, m_fall, m_glitch;
   logic [EW-1:0] m_evt, m_gcnt;
   bit            chk_en = 1'b0;

   always @(posedge c) begin : model
      logic s_m;
      logic acc;
      s_m = hist[$];
      hist.pop_back();
      hist.push_front(i);
      acc      = 1'b0;
      m_rise   = 1'b0;
      m_fall   = 1'b0;
      m_glitch = 1'b0;
      if (r) begin
         m_o    = 1'b0;
         pend   = 0;
         m_evt  = '0;
         m_gcnt = '0;
      end else begin
         if (s_m != m_o) begin
            pend++;
            if (pend == DEB) begin
               acc = 1'b1;
               m_o = s_m;
               if (s_m) m_rise = 1'b1;
               else     m_fall = 1'b1;
               pend = 0;
            end
         end else begin
            if (pend > 0) m_glitch = 1'b1;
            pend = 0;
         end
         m_evt  = clr ? '0 : m_evt + EW'(acc);
         m_gcnt = clr ? '0 : m_gcnt + EW'(m_glitch);
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   int n_rise0 = 0, n_fall0 = 0, n_glit0 = 0;
   int n_rise1 = 0, n_fall1 = 0, n_glit1 = 0;

   always @(negedge c) begin
      if (chk_en) begin
         check("o", o, m_o);
         check("rise", rise, m_rise);
         check("fall", fall, m_fall);
         check("glitch", glitch, m_glitch);
         check("evt_cnt", evt, m_evt);
         check("state", st, m_o ? (pend > 0 ? CHK_LO : ST_HI) : (pend > 0 ? CHK_HI : ST_LO));
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
         check("glitch_cnt", gcnt, m_gcnt);
`endif
         n_rise0 += int'(rise);
         n_fall0 += int'(fall);
         n_glit0 += int'(glitch);
         n_rise1 += int'(rise1);
         n_fall1 += int'(fall1);
         n_glit1 += int'(glitch1);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(negedge c);
         #1;
      end
   endtask

   // Steps until the chosen pulse is seen; gives up after 20 cycles.
   task automatic wait_pulse(input bit on_dut1, output int lat);
      lat = 0;
      do begin
         step(1);
         lat++;
      end while (!(on_dut1 ? fall1 : rise) && lat < 20);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int lat, g0, r0, f0, len;
      logic lvl;
      r = 1'b1; i = 1'b0; clr = 1'b0; i1 = 1'b1;
      for (int k = 0; k < N; k++) hist.push_back(1'b0);
      @(posedge c);
      chk_en = 1'b1;
      step(4);
      check("rst_o", o, 0);
      check("rst_evt", evt, 0);
      check("rst_state", st, ST_LO);
      check("rst_o1", o1, 1);
      r = 1'b0;
      step(6);

      // Clean rise: 2 sync flops + 4 debounce samples
      i = 1'b1;
      wait_pulse(1'b0, lat);
      check("rise_latency", lat, 6);
      check("rise_o", o, 1);
      check("rise_evt", evt, 1);
      check("rise_no_glitch", n_glit0, 0);
      i = 1'b0;
      step(8);
      check("fall_o", o, 0);
      check("fall_evt", evt, 2);

      // Short pulse is rejected
      clr = 1'b1; step(1); clr = 1'b0;
      check("clr_evt", evt, 0);
      g0 = n_glit0; r0 = n_rise0;
      i = 1'b1; step(2); i = 1'b0; step(8);
      check("glitch_once", n_glit0 - g0, 1);
      check("glitch_no_rise", n_rise0 - r0, 0);
      check("glitch_o", o, 0);
      check("glitch_evt", evt, 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      check("glitch_cnt_one", gcnt, 1);
`endif

      // 16 accepted edges wrap the 4-bit counter
      repeat (8) begin
         i = 1'b1; step(8);
         i = 1'b0; step(8);
      end
      check("wrap_evt0", evt, 0);
      i = 1'b1; step(8);
      check("wrap_evt1", evt, 1);
      i = 1'b0; step(8);

      // clr on the accepting edge
      i = 1'b1; step(5);
      clr = 1'b1; step(1);
      check("clr_rise", rise, 1);
      check("clr_rise_o", o, 1);
      check("clr_rise_evt", evt, 0);
      clr = 1'b0;
      i = 1'b0; step(8);

      // Reset while two samples into a pending rise
      i = 1'b1; step(4);
      check("mid_chk_state", st, CHK_HI);
      r = 1'b1; i = 1'b0;
      #1;
      check("async_rst_state", st, ST_LO);
      step(3);
      r = 1'b0;
      g0 = n_glit0; r0 = n_rise0; f0 = n_fall0;
      step(6);
      check("post_rst_pulses", (n_glit0 - g0) + (n_rise0 - r0) + (n_fall0 - f0), 0);
      check("post_rst_o", o, 0);
      check("post_rst_state", st, ST_LO);
      i = 1'b1;
      wait_pulse(1'b0, lat);
      check("post_rst_latency", lat, 6);
      i = 1'b0; step(8);

      // Randomized runs with sparse clears and resets
      repeat (250) begin
         lvl = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 7);
         repeat (len) begin
            i   = lvl;
            clr = ($urandom_range(0, 31) == 0);
            r   = ($urandom_range(0, 299) == 0);
            step(1);
         end
      end
      r = 1'b0; clr = 1'b0;
      step(2);

      // INIT=1 instance held high through everything so far
      check("init1_o", o1, 1);
      check("init1_quiet", n_rise1 + n_fall1 + n_glit1, 0);
      i1 = 1'b0;
      wait_pulse(1'b1, lat);
      check("init1_fall_latency", lat, 6);
      check("init1_fall_o", o1, 0);
      step(2);
      check("init1_one_fall", n_fall1, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
